// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the register file: WB has priority, LD/DBG share a
// round-robin slot with starvation override, and a clear sequence rewrites x1..x31.
module regfile_write_arbiter #(
    parameter logic [31:0] STACK_ADDRESS = 32'h1000_3FFC,
    parameter int unsigned STARVE_LIMIT  = 4
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iWbValid,
    input  logic [4:0]  iWbReg,
    input  logic [31:0] iWbData,
    output logic        oWbReady,
    input  logic        iLdValid,
    input  logic [4:0]  iLdReg,
    input  logic [31:0] iLdData,
    output logic        oLdReady,
    input  logic        iDbgValid,
    input  logic [4:0]  iDbgReg,
    input  logic [31:0] iDbgData,
    output logic        oDbgReady,
    input  logic        iClearReq,
    output logic        oRegWrite,
    output logic [4:0]  oWriteRegister,
    output logic [31:0] oWriteData,
    output logic        oBusy,
    output logic        oClearDone
);

    localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [4:0] LAST_INDEX = 5'd31;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    typedef enum logic {
        PTR_LD,
        PTR_DBG
    } ptr_t;

    state_t           state;
    state_t           nextState;
    ptr_t             rrPtr;
    logic [4:0]       clrIndex;
    logic [CNT_W-1:0] ldStarve;
    logic [CNT_W-1:0] dbgStarve;
    logic             armed;

    logic             blocked;
    logic             ldStarved;
    logic             dbgStarved;
    logic             grantWb;
    logic             grantLd;
    logic             grantDbg;
    logic             anyGrant;
    logic [4:0]       selReg;
    logic [31:0]      selData;

    // armed keeps every ready low while reset is asserted without feeding the
    // asynchronous reset pin into the datapath logic.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE: begin
                if (iClearReq) begin
                    nextState = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (clrIndex == LAST_INDEX) begin
                    nextState = ST_IDLE;
                end
            end
            default: nextState = ST_IDLE;
        endcase
    end

    // A pending clear blocks arbitration in the same cycle it is requested.
    always_comb begin
        blocked    = !armed || (state == ST_CLEAR) || iClearReq;
        ldStarved  = iLdValid && (ldStarve == CNT_MAX);
        dbgStarved = iDbgValid && (dbgStarve == CNT_MAX);
        grantWb    = 1'b0;
        grantLd    = 1'b0;
        grantDbg   = 1'b0;
        if (!blocked) begin
            if (ldStarved && dbgStarved) begin
                grantLd  = (rrPtr == PTR_LD);
                grantDbg = (rrPtr == PTR_DBG);
            end else if (ldStarved) begin
                grantLd = 1'b1;
            end else if (dbgStarved) begin
                grantDbg = 1'b1;
            end else if (iWbValid) begin
                grantWb = 1'b1;
            end else if (iLdValid && iDbgValid) begin
                grantLd  = (rrPtr == PTR_LD);
                grantDbg = (rrPtr == PTR_DBG);
            end else if (iLdValid) begin
                grantLd = 1'b1;
            end else if (iDbgValid) begin
                grantDbg = 1'b1;
            end
        end
    end

    always_comb begin
        selReg   = 5'd0;
        selData  = 32'd0;
        anyGrant = grantWb || grantLd || grantDbg;
        if (grantWb) begin
            selReg  = iWbReg;
            selData = iWbData;
        end else if (grantLd) begin
            selReg  = iLdReg;
            selData = iLdData;
        end else if (grantDbg) begin
            selReg  = iDbgReg;
            selData = iDbgData;
        end
    end

    assign oWbReady  = grantWb;
    assign oLdReady  = grantLd;
    assign oDbgReady = grantDbg;
    assign oBusy     = (state == ST_CLEAR);

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            clrIndex <= 5'd1;
        end else if (state == ST_CLEAR) begin
            clrIndex <= (clrIndex == LAST_INDEX) ? 5'd1 : clrIndex + 5'd1;
        end else if (nextState == ST_CLEAR) begin
            clrIndex <= 5'd1;
        end
    end

    // Counters saturate at the limit so a starved requester that loses a tie
    // keeps its override for the following cycle.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            rrPtr     <= PTR_LD;
            ldStarve  <= '0;
            dbgStarve <= '0;
        end else if (!blocked) begin
            if (grantLd) begin
                rrPtr <= PTR_DBG;
            end else if (grantDbg) begin
                rrPtr <= PTR_LD;
            end
            if (grantLd) begin
                ldStarve <= '0;
            end else if (iLdValid && (ldStarve != CNT_MAX)) begin
                ldStarve <= ldStarve + 1'b1;
            end
            if (grantDbg) begin
                dbgStarve <= '0;
            end else if (iDbgValid && (dbgStarve != CNT_MAX)) begin
                dbgStarve <= dbgStarve + 1'b1;
            end
        end
    end

    // Register 0 is accepted like any other target but never written.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oRegWrite      <= 1'b0;
            oWriteRegister <= 5'd0;
            oWriteData     <= 32'd0;
            oClearDone     <= 1'b0;
        end else begin
            oRegWrite  <= 1'b0;
            oClearDone <= 1'b0;
            if (state == ST_CLEAR) begin
                oRegWrite      <= 1'b1;
                oWriteRegister <= clrIndex;
                oWriteData     <= (clrIndex == 5'd2) ? STACK_ADDRESS : 32'd0;
                oClearDone     <= (clrIndex == LAST_INDEX);
            end else if (anyGrant) begin
                oRegWrite      <= (selReg != 5'd0);
                oWriteRegister <= selReg;
                oWriteData     <= selData;
            end
        end
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter STACK_ADDRESS, default 32'h1000_3FFC, value loaded into x2 (sp) by the clear sequence.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, the consecutive denied cycles after which a low-priority requester overrides WB.
REQ-003 SHALL have port iCLK, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port iRST, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports iWbValid/iWbReg/iWbData, input, 1/5/32, pipeline writeback request (requester WB).
REQ-006 SHALL have port oWbReady, output, 1, WB accepted this cycle.
REQ-007 SHALL have ports iLdValid/iLdReg/iLdData, input, 1/5/32, multicycle load-unit request (requester LD).
REQ-008 SHALL have port oLdReady, output, 1, LD accepted this cycle.
REQ-009 SHALL have ports iDbgValid/iDbgReg/iDbgData, input, 1/5/32, debug-host request (requester DBG).
REQ-010 SHALL have port oDbgReady, output, 1, DBG accepted this cycle.
REQ-011 SHALL have port iClearReq, input, 1, request to reinitialise the whole register file.
REQ-012 SHALL have ports oRegWrite/oWriteRegister/oWriteData, output, 1/5/32, registered drive of the register-file write port.
REQ-013 SHALL have port oBusy, output, 1, clear sequence in progress.
REQ-014 SHALL have port oClearDone, output, 1, one-cycle pulse when the clear sequence completes.

Function
REQ-015 SHALL transfer a request when valid and ready are both high at a rising edge; ready is combinational from current state and valids, at most one ready high per cycle.
REQ-016 SHALL require requesters to hold valid, reg and data stable until accepted; ready never asserts without the matching valid.
REQ-017 SHALL register the accepted request so oRegWrite/oWriteRegister/oWriteData reflect it exactly one cycle after the handshake edge; oRegWrite is low in cycles with no transfer.
REQ-018 SHALL grant WB whenever iWbValid is high, unless a starvation override (REQ-020) is active.
REQ-019 SHALL arbitrate LD vs DBG round-robin: pointer starts at LD, moves to the other requester after each LD or DBG grant; WB grants leave the pointer unchanged.
REQ-020 SHALL keep a per-requester counter for LD and DBG, incremented each cycle that requester is valid and not granted, cleared on its grant; when a counter equals STARVE_LIMIT that requester is granted over WB (oWbReady low); if both reach it, the round-robin pointer decides.
REQ-021 SHALL accept a request targeting register 0 normally (ready, round-robin and counters update) but hold oRegWrite low for it.
REQ-022 SHALL implement FSM IDLE/CLEAR: in IDLE, iClearReq high at an edge enters CLEAR with index 1; all readies are low while iClearReq is high in IDLE and throughout CLEAR.
REQ-023 SHALL, in CLEAR, emit one write per cycle for indices 1..31 in ascending order (data 0, except index 2 gets STACK_ADDRESS), so oRegWrite is high for exactly 31 consecutive cycles.
REQ-024 SHALL, at the edge issuing index 31, return to IDLE and pulse oClearDone high for the following cycle; oBusy is high exactly while the FSM is in CLEAR.
REQ-025 SHALL ignore iClearReq while in CLEAR, and never restart or extend a running sequence.
REQ-026 SHALL leave starvation counters frozen and the round-robin pointer unchanged during CLEAR.

Reset
REQ-027 SHALL, while iRST is low, asynchronously force FSM to IDLE, index to 1, pointer to LD, counters to 0, and oRegWrite, oWriteRegister, oWriteData, oBusy, oClearDone to 0; readies low.
REQ-028 SHALL abort a clear sequence on reset mid-operation with no further clear writes after reset release.

Verification
REQ-029 SHALL be verified: WB valid reg=5 data=32'hDEADBEEF alone -> oWbReady high same cycle; next cycle oRegWrite=1, oWriteRegister=5, oWriteData=32'hDEADBEEF.
REQ-030 SHALL be verified: LD and DBG valid for 4 cycles, WB idle -> grants LD, DBG, LD, DBG, each write one cycle after its handshake.
REQ-031 SHALL be verified: WB valid continuously, LD valid from cycle 0 -> LD denied cycles 0-3, granted in cycle 4 with oWbReady low, WB resumes in cycle 5.
REQ-032 SHALL be verified: iClearReq pulse with all requesters valid -> readies low 32 cycles, 31 writes x1..x31 with x2=STACK_ADDRESS, oClearDone pulses once, oBusy falls, arbitration resumes.
REQ-033 SHALL be verified: DBG writes reg=0 data=32'h1 -> oDbgReady high, oRegWrite stays low next cycle, pointer advances to LD.
REQ-034 SHALL be verified: iRST low after 10 clear writes -> outputs 0 immediately, after release no further clear writes, oClearDone never pulses.
